uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of `uart_transmitter`. It oversamples an asynchronous 8N1 line (`rx_serial`) with the system clock and samples each bit at mid-bit. Received bytes are buffered in a FIFO, and the FIFO is presented on a valid/ready consumer port. It sits between the board-level RX pin and the same byte-stream fabric that feeds `uart_transmitter`.

## Interface
- `CLK_FREQ`, 1_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer division, must be at least 4). `HALF_BIT = CLKS_PER_BIT/2`.
- `FIFO_DEPTH`, 8: receive FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid` is 1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `rx_busy`  out  1  FSM is not in IDLE.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- `rx_serial` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM sees only the synchronized line.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- IDLE: synchronized line low → START, with the baud counter cleared.
- START: at `HALF_BIT-1` counts, sample the line. If low → DATA with the counter cleared. If high → IDLE; this is a glitch, with no byte and no error.
- DATA: every `CLKS_PER_BIT` counts, sample one bit into the shift register, LSB first. After the 8th bit → STOP.
- STOP: at `CLKS_PER_BIT` counts, sample the line.
  - If high: push the byte, or pulse `overrun` if the FIFO is full and no pop occurs that cycle.
  - If low: pulse `frame_error` and discard the byte.
  - Either way → IDLE on the same edge.
- Because STOP exits at mid-stop-bit, back-to-back frames with no idle gap are received.
- FIFO is show-ahead: `rx_data` = head entry, `rx_valid` = !empty, and a pop happens on `rx_valid && rx_ready`.
- Push and pop in the same cycle:
  - FIFO full: both are accepted, count unchanged, no overrun.
  - FIFO empty: the pop is ignored because `rx_valid` is 0; the push happens.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_error`=0, `overrun`=0. FSM in IDLE, FIFO empty, counters 0, synchronizer 1.
- Reset asserted mid-frame: the frame is abandoned and the FIFO is flushed immediately. After release, the FSM waits in IDLE for the next falling edge. A line already low at release starts a frame, and that frame then fails START or STOP validation.
- Start detection latency: a line falling edge at pin is seen by the FSM 2–3 cycles later.
- Data bit n (0..7) is sampled `HALF_BIT + (n+1)*CLKS_PER_BIT` cycles after START entry. The stop bit is sampled at `HALF_BIT + 9*CLKS_PER_BIT`.
- The byte is written on the stop-sample edge. `rx_valid` is 1 in the next cycle.
- `frame_error` and `overrun` are high for exactly one cycle, the cycle after the stop-sample edge.
- `rx_busy` rises on START entry and falls on return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP. The parity bit is sampled `CLKS_PER_BIT` after the 8th data bit, and expected parity is even.
  - An extra output `parity_error` (1 bit, reset 0) pulses for one cycle alongside the stop-sample result when parity mismatches. The byte is discarded.
  - The stop bit moves to `HALF_BIT + 10*CLKS_PER_BIT`.
  - The peer `uart_transmitter` must be built with matching parity.
- `UART_RX_PARITY_EN` undefined: 8N1 only. There is no PARITY state and no `parity_error` port.

## Test plan
All scenarios use defaults: `CLKS_PER_BIT` = 104, `HALF_BIT` = 52.

- Single byte: drive frame 0x55 with `rx_ready`=1 → `rx_valid` pulses one cycle with `rx_data`=0x55. No error pulses, and `rx_busy` returns to 0.
- Back-to-back frames: send 0xA3 then 0xFF with zero idle gap and `rx_ready`=0 → FIFO holds 0xA3 then 0xFF. Two pops with `rx_ready`=1 return them in that order, then `rx_valid`=0.
- Glitch rejection: pull `rx_serial` low for 20 cycles, then high → FSM returns to IDLE, no FIFO write, no `frame_error`.
- Framing error: send 0x3C with the stop bit low → one-cycle `frame_error`, FIFO stays empty.
- Overrun and simultaneous push/pop, with `rx_ready`=0:
  - Send 9 bytes 0x01..0x09 → 8 bytes stored and one `overrun` pulse on byte 9.
  - Pop during the stop-sample cycle of a 10th byte 0x0A → it is stored and there is no overrun.
- Reset mid-frame: assert `rst` during data bit 4 of 0x81 with 2 bytes already queued → all outputs return to reset values at once and the FIFO is empty. A following 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_receiver #(
    parameter int CLK_FREQ   = 1_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_error,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       overrun
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic             r_sync1, r_sync2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_frame_err, r_overrun;
    logic             w_stop_smp, w_good, w_ferr;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop, w_push, w_full, w_ovr;

`ifdef UART_RX_PARITY_EN
    logic r_par, w_par_nxt, w_perr, r_parity_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    // a start bit that is high again at mid-bit was a glitch
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_sync2;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    // leaving at mid-stop-bit lets a back-to-back start edge be caught
                    w_cnt_nxt   = '0;
                    w_stop_smp  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_perr = w_stop_smp & (^{r_shift, r_par});
    assign w_good = w_stop_smp & r_sync2 & ~w_perr;
`else
    assign w_good = w_stop_smp & r_sync2;
`endif
    assign w_ferr = w_stop_smp & ~r_sync2;

    assign w_pop  = rx_valid & rx_ready;
    assign w_full = (r_count == CNT_MAX);
    assign w_push = w_good & (~w_full | w_pop);
    assign w_ovr  = w_good & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_perr;
`endif
        end
    end

    assign rx_valid    = (r_count != '0);
    assign rx_data     = rx_valid ? r_mem[r_rptr] : 8'h00;
    assign rx_busy     = (r_state != S_IDLE);
    assign frame_error = r_frame_err;
    assign overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit-serially, received bytes checked
// against a scoreboard queue filled when each good frame is sent.
module tb_uart_receiver;
    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun;

    int total  = 0;
    int passed = 0;
    int vcyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] sb [$];

    uart_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // caller is at a negedge; returns at a negedge right after the stop bit
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_serial = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // sample between negedge input changes and the next posedge
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (rx_valid)    vcyc++;
            if (frame_error) fe_cnt++;
            if (overrun)     ov_cnt++;
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) check("pop_unexpected", 32'(rx_data), 32'hxx);
                else check("pop_data", 32'(rx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_serial = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_busy", 32'(rx_busy), 0);
        check("rst_ferr", 32'(frame_error), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single byte, consumer always ready
        rx_ready = 1'b1; vcyc = 0;
        sb.push_back(8'h55);
        send(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        check("single_vcyc", 32'(vcyc), 1);
        check("single_ferr", 32'(fe_cnt), 0);
        check("single_ovr", 32'(ov_cnt), 0);
        check("single_busy", 32'(rx_busy), 0);
        check("single_sb", 32'(sb.size()), 0);

        // back-to-back frames held in the FIFO
        rx_ready = 1'b0;
        sb.push_back(8'hA3); sb.push_back(8'hFF);
        send(8'hA3, 1'b1);
        send(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b_valid", 32'(rx_valid), 1);
        check("b2b_head", 32'(rx_data), 32'hA3);
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        check("b2b_empty", 32'(rx_valid), 0);
        check("b2b_sb", 32'(sb.size()), 0);

        // 20-cycle low glitch
        rx_serial = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_hi", 32'(rx_busy), 1);
        rx_serial = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_lo", 32'(rx_busy), 0);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_ferr", 32'(fe_cnt), 0);

        // framing error: stop bit low
        send(8'h3C, 1'b0);
        rx_serial = 1'b1;
        repeat (200) @(negedge clk);
        check("ferr_pulse", 32'(fe_cnt), 1);
        check("ferr_valid", 32'(rx_valid), 0);
        check("ferr_busy", 32'(rx_busy), 0);

        // overrun: 9 bytes into an 8-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) sb.push_back(8'(i));
            send(8'(i), 1'b1);
        end
        repeat (10) @(negedge clk);
        check("ovr_pulse", 32'(ov_cnt), 1);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_head", 32'(rx_data), 32'h01);

        // full FIFO, pop on the stop-sample edge of byte 0x0A
        sb.push_back(8'h0A);
        fork
            send(8'h0A, 1'b1);
            begin
                repeat (990) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("simul_ovr", 32'(ov_cnt), 1);
        check("simul_sb", 32'(sb.size()), 8);
        rx_ready = 1'b1;
        repeat (12) @(negedge clk);
        rx_ready = 1'b0;
        check("drain_sb", 32'(sb.size()), 0);
        check("drain_valid", 32'(rx_valid), 0);

        // reset during data bit 4 of 0x81 with two bytes queued
        sb.push_back(8'h11); sb.push_back(8'h22);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        check("pre_rst_valid", 32'(rx_valid), 1);
        fork
            send(8'h81, 1'b1);
            begin
                repeat (560) @(negedge clk);
                rst = 1'b1;
                #1;
                check("mid_rst_valid", 32'(rx_valid), 0);
                check("mid_rst_data", 32'(rx_data), 0);
                check("mid_rst_busy", 32'(rx_busy), 0);
                check("mid_rst_ferr", 32'(frame_error), 0);
                check("mid_rst_ovr", 32'(overrun), 0);
            end
        join
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_valid", 32'(rx_valid), 0);
        rx_ready = 1'b1;
        sb.push_back(8'h7E);
        send(8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        check("post_rst_sb", 32'(sb.size()), 0);
        check("end_ferr", 32'(fe_cnt), 1);
        check("end_ovr", 32'(ov_cnt), 1);
        check("end_valid", 32'(rx_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
